// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse_sched stretch scheduler: FSM encoding and
// the stored-length substitution used when a zero length is written.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  // A zero-length stretch is meaningless; it is stored as this value instead.
  localparam int ZERO_LEN_SUBST = 1;

endpackage

// File: rtl/pulse_sched_rr_pick.sv
// Combinational round-robin picker: returns the first pending channel at or
// after rr_ptr, wrapping modulo N_CH.
module rr_pick
  import pulse_sched_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int                 pos;
  logic [IDX_W-1:0]   pos_idx;

  // Scan from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    valid   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      pos     = (int'(rr_ptr) + k) % N_CH;
      pos_idx = IDX_W'(pos);
      if (pending[pos_idx]) begin
        valid = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Multi-channel pulse stretch scheduler sharing one programmable timer.
// Optional sticky overflow flag built when PULSE_SCHED_OVF_EN is defined.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int DEF_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_pulse,
  input  logic                     cfg_we,
  input  logic [CNT_W-1:0]         cfg_len,
  output logic [N_CH-1:0]          out_pulse,
  output logic                     busy,
  output logic [$clog2(N_CH)-1:0]  grant_id,
  output logic                     ovf
);

  localparam int IDX_W = $clog2(N_CH);

  state_t             state_q, state_d;
  logic [N_CH-1:0]    prev_q;
  logic [N_CH-1:0]    pending_q, pending_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [N_CH-1:0]    out_q, out_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    clr;
  logic [N_CH-1:0]    pick_vec;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending (pending_q),
    .rr_ptr  (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  always_comb begin
    req      = in_pulse & ~prev_q;
    pick_vec = '0;
    pick_vec[pick_idx] = 1'b1;

    len_d = len_q;
    if (cfg_we) begin
      len_d = (cfg_len == '0) ? CNT_W'(ZERO_LEN_SUBST) : cfg_len;
    end

    state_d = state_q;
    timer_d = timer_q;
    out_d   = out_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    clr     = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          clr     = pick_vec;
          timer_d = len_q - CNT_W'(1);
          out_d   = pick_vec;
          grant_d = pick_idx;
          ptr_d   = (pick_idx == IDX_W'(N_CH - 1)) ? '0 : pick_idx + IDX_W'(1);
          state_d = ST_STRETCH;
        end
      end
      ST_STRETCH: begin
        if (timer_q == '0) begin
          out_d   = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        out_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // A new request wins over a same-cycle grant so it is not lost.
    pending_d = (pending_q & ~clr) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      len_q     <= CNT_W'(DEF_LEN);
      timer_q   <= '0;
      out_q     <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= in_pulse;
      pending_q <= pending_d;
      len_q     <= len_d;
      timer_q   <= timer_d;
      out_q     <= out_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef PULSE_SCHED_OVF_EN
  logic ovf_q, ovf_d;

  // A request landing on an already-pending, not-just-granted channel is merged.
  always_comb begin
    ovf_d = ovf_q | (|(req & pending_q & ~clr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_pulse = out_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == ST_STRETCH) || (state_q == ST_GAP);

endmodule

// File: tb/tb_pulse_sched.sv
// Scoreboard bench for pulse_sched: stimulus queues expected pulses, a
// negedge monitor measures each stretched pulse and compares against them.
module tb_pulse_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_pulse;
  logic       cfg_we;
  logic [7:0] cfg_len;
  logic [3:0] out_pulse;
  logic       busy;
  logic [1:0] grant_id;
  logic       ovf;

  always #5 clk = ~clk;

  pulse_sched #(
    .N_CH    (4),
    .CNT_W   (8),
    .DEF_LEN (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pulse  (in_pulse),
    .cfg_we    (cfg_we),
    .cfg_len   (cfg_len),
    .out_pulse (out_pulse),
    .busy      (busy),
    .grant_id  (grant_id),
    .ovf       (ovf)
  );

`ifdef PULSE_SCHED_OVF_EN
  localparam int EXP_OVF = 1;
`else
  localparam int EXP_OVF = 0;
`endif

  typedef struct {
    int ch;
    int len;
    int gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle high then one cycle low, starting and ending at a negedge.
  task automatic applyStimulus(input logic [3:0] v);
    in_pulse = v;
    @(negedge clk);
    in_pulse = '0;
    @(negedge clk);
  endtask

  task automatic expectPulse(input int ch, input int len, input int gap);
    exp_t e;
    e.ch  = ch;
    e.len = len;
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic writeLen(input int len);
    cfg_we  = 1'b1;
    cfg_len = 8'(len);
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: measures each out_pulse burst (vector, length, grant, preceding gap).
  initial begin
    logic [3:0] run_vec;
    int         run_len;
    int         run_gap;
    int         run_grant;
    int         low_cnt;
    exp_t       e;
    run_vec   = '0;
    run_len   = 0;
    run_gap   = 0;
    run_grant = 0;
    low_cnt   = 1000;
    forever begin
      @(negedge clk);
      if (run_vec != '0 && out_pulse != run_vec) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_extra_pulse", int'(run_vec), 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("pulse_vec", int'(run_vec), 1 << e.ch);
          checkOutput("pulse_len", run_len, e.len);
          checkOutput("pulse_grant", run_grant, e.ch);
          if (e.gap >= 0) begin
            checkOutput("pulse_gap", run_gap, e.gap);
          end
        end
        run_vec = '0;
        low_cnt = 0;
      end
      if (out_pulse != '0) begin
        if (run_vec == '0) begin
          checkOutput("pulse_onehot", int'($onehot(out_pulse)), 1);
          run_vec   = out_pulse;
          run_len   = 1;
          run_gap   = low_cnt;
          run_grant = int'(grant_id);
        end else begin
          run_len++;
        end
      end else begin
        low_cnt++;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_pulse = '0;
    cfg_we   = 1'b0;
    cfg_len  = '0;
    idle(3);
    checkOutput("rst_out_pulse", int'(out_pulse), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_grant_id", int'(grant_id), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    idle(1);

    // Single request on ch1: output rises two edges after the request is sampled.
    expectPulse(1, 4, -1);
    in_pulse = 4'b0010;
    @(negedge clk);
    checkOutput("lat_early", int'(out_pulse), 0);
    in_pulse = '0;
    @(negedge clk);
    checkOutput("lat_start", int'(out_pulse), 2);
    checkOutput("busy_on", int'(busy), 1);
    idle(10);
    checkOutput("busy_off", int'(busy), 0);

    // Programmed lengths, including zero stored as one.
    writeLen(7);
    expectPulse(0, 7, -1);
    applyStimulus(4'b0001);
    idle(12);
    writeLen(0);
    expectPulse(0, 1, -1);
    applyStimulus(4'b0001);
    idle(6);

    // Fresh reset: pointer 0, length back to 4; three channels at once.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    expectPulse(0, 4, -1);
    expectPulse(2, 4, 2);
    expectPulse(3, 4, 2);
    applyStimulus(4'b1101);
    idle(25);
    expectPulse(0, 4, -1);
    expectPulse(3, 4, 2);
    applyStimulus(4'b1001);
    idle(16);

    // Two ch2 requests during a ch1 stretch merge into one service.
    expectPulse(1, 4, -1);
    expectPulse(2, 4, 2);
    applyStimulus(4'b0010);
    applyStimulus(4'b0100);
    applyStimulus(4'b0100);
    idle(14);
    checkOutput("ovf_merge", int'(ovf), EXP_OVF);

    // Reset two cycles into a stretch drops the output and the pending ch3.
    expectPulse(0, 2, -1);
    applyStimulus(4'b0001);
    in_pulse = 4'b1000;
    @(negedge clk);
    in_pulse = '0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_out", int'(out_pulse), 0);
    checkOutput("rst_mid_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(14);
    checkOutput("ovf_cleared", int'(ovf), 0);

    // Input held high across reset release counts as exactly one request.
    rst = 1'b1;
    in_pulse = 4'b0001;
    idle(2);
    rst = 1'b0;
    expectPulse(0, 4, -1);
    idle(12);
    in_pulse = '0;
    idle(4);

    checkOutput("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_sched.md
# pulse_sched

Multi-channel pulse stretch scheduler: captures single-cycle (or longer) request pulses on `N_CH` input channels and shares one programmable stretch timer among them, issuing one stretched output pulse at a time under round-robin arbitration. It sits in front of the per-channel pulse outputs wherever several event sources need pulses widened by a common, runtime-configurable length without instantiating one counter per channel.

## Interface
- `N_CH`, 4: number of request/output channels (2..16)
- `CNT_W`, 8: width of stretch length and timer
- `DEF_LEN`, 4: stretch length loaded at reset (cycles)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_pulse`  in  N_CH  per-channel request; a rising edge is one request
- `cfg_we`  in  1  write strobe for `cfg_len`
- `cfg_len`  in  CNT_W  new stretch length in cycles
- `out_pulse`  out  N_CH  stretched pulse, at most one bit high (one-hot or zero)
- `busy`  out  1  high in STRETCH and GAP
- `grant_id`  out  $clog2(N_CH)  channel currently/last granted
- `ovf`  out  1  sticky request-overflow flag (see Configuration)

## Operation
- Edge detect: `prev[i]` registers `in_pulse[i]`; request when `in_pulse[i] & ~prev[i]`. `prev` resets to 0, so an input already high at reset release counts as one request.
- `pending[i]` set on request, cleared on grant to i; if both in the same cycle, set wins (new request retained).
- `len_q` loaded from `cfg_len` on `cfg_we`; value 0 stored as 1. Write during STRETCH affects the next grant only.
- FSM:
  - IDLE: if any `pending`, grant the first pending channel at or after `rr_ptr` (wrap modulo N_CH). Load timer = `len_q`-1, set `out_pulse[g]`, `grant_id`=g, `rr_ptr`=g+1 mod N_CH. Go to STRETCH. Else stay.
  - STRETCH: if timer==0, clear `out_pulse`, go to GAP; else decrement.
  - GAP: one cycle all outputs low, go to IDLE.
- Requests arriving during STRETCH/GAP are queued in `pending`, never lost, except a second request on a channel whose `pending` is already set (and not cleared that cycle): merged, and sets `ovf` when enabled.

## Timing
- Reset values: `out_pulse`=0, `busy`=0, `grant_id`=0, `ovf`=0, `pending`=0, `rr_ptr`=0, `len_q`=DEF_LEN, state IDLE.
- Request sampled at edge E0 -> `pending` high after E0 -> grant at E1 -> `out_pulse` high after E1 for exactly `len_q` cycles.
- Back-to-back grants separated by exactly 2 low cycles (GAP + IDLE decision).
- `rst` mid-stretch: `out_pulse` drops next edge; all pending requests discarded.
- Timer arithmetic unsigned CNT_W bits; max stretch 2^CNT_W-1 cycles.

## Configuration
- `PULSE_SCHED_OVF_EN` defined: `ovf` sets on a merged request (per Operation), stays high until `rst`.
- Undefined: overflow logic not built, `ovf` tied 0; merging behaviour unchanged.

## Structure
- Shared package: FSM state encoding (IDLE, STRETCH, GAP) and the length-zero-to-one rule constant.
- One sub-module: `rr_pick` — combinational round-robin priority picker (`pending`, `rr_ptr` -> grant valid, index).

## Test plan
- Reset, `in_pulse[1]` high one cycle -> `out_pulse` = 4'b0010 for 4 cycles starting 2 edges later, `grant_id`=1.
- `cfg_len`=7 written, pulse on ch0 -> `out_pulse[0]` high 7 cycles; `cfg_len`=0 -> 1 cycle.
- Pulses on ch0, ch2, ch3 same cycle -> served 0, 2, 3 in order, each 4 cycles, 2-cycle gaps; then ch0 again pulses with ch3 -> rr from ptr=0: ch0 served first.
- ch2 pulsed twice during ch1 stretch -> ch2 served once; `ovf`=1 with `PULSE_SCHED_OVF_EN`, 0 without.
- `rst` asserted 2 cycles into a 4-cycle stretch with ch3 pending -> `out_pulse`=0 next edge, ch3 never served.
- `in_pulse[0]` held high through reset release -> exactly one stretched pulse on ch0.
